// File: rtl/rm_feeder_pkg.sv
// Shared types and constants for the runtime-monitor symbol feeder.
// Holds the sequencing states, the symbol width and the default end-of-trace code.
package rm_feeder_pkg;

    localparam int SYM_W = 8;
    localparam logic [SYM_W-1:0] EOT_SYM_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_EOT,
        ST_CLEAR
    } state_e;

    // Only the two steady states take new trace symbols; the flush sequence ignores them.
    function automatic logic accepts_input(input state_e s);
        return (s == ST_IDLE) || (s == ST_STREAM);
    endfunction

endpackage

// File: rtl/rm_sym_fifo.sv
// Circular symbol buffer with extra-MSB read/write pointers for full/empty detection.
// A push into a full buffer is taken only when a pop happens in the same cycle.
module rm_sym_fifo
    import rm_feeder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [SYM_W-1:0] push_data,
    input  logic             pop,
    output logic [SYM_W-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [SYM_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rm_symbol_feeder.sv
// Trace-symbol front end for the monitor clusters: buffers an unstallable trace tap,
// streams symbols with a run qualifier, and sequences drain / end-of-trace / monitor clear.
module rm_symbol_feeder
    import rm_feeder_pkg::*;
#(
    parameter int               DEPTH   = 8,
    parameter logic [SYM_W-1:0] EOT_SYM = EOT_SYM_DEFAULT,
    parameter int               DROP_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [SYM_W-1:0]  in_sym,
    output logic [SYM_W-1:0]  symbols,
    output logic              run,
    output logic              mon_clear,
    output logic              busy,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [SYM_W-1:0]  symbols_q, symbols_d;
    logic              run_q, run_d;
    logic              mon_clear_q, mon_clear_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic [SYM_W-1:0]  fifo_head;
    logic              push;
    logic              pop;
    logic              accepting;
    logic              drop;

    rm_sym_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(in_sym),
        .pop      (pop),
        .rd_data  (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (en) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_EOT;
                end
            end
            ST_EOT:   state_d = ST_CLEAR;
            ST_CLEAR: state_d = en ? ST_STREAM : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output registers are loaded on the edge that enters a state, so EOT and CLEAR
    // cycles line up with their run / mon_clear pulses.
    always_comb begin
        pop         = 1'b0;
        symbols_d   = symbols_q;
        run_d       = 1'b0;
        mon_clear_d = 1'b0;
        case (state_q)
            ST_STREAM: pop = en && !flush && !fifo_empty;
            ST_DRAIN:  pop = !fifo_empty;
            default:   pop = 1'b0;
        endcase
        if (pop) begin
            symbols_d = fifo_head;
            run_d     = 1'b1;
        end
        if ((state_q == ST_DRAIN) && fifo_empty) begin
            symbols_d = EOT_SYM;
            run_d     = 1'b1;
        end
        if (state_q == ST_EOT) begin
            mon_clear_d = 1'b1;
        end
    end

    // A pop in the same cycle frees the slot, so a full buffer still accepts while streaming.
    always_comb begin
        accepting  = accepts_input(state_q);
        push       = in_valid && accepting && (!fifo_full || pop);
        drop       = in_valid && accepting && fifo_full && !pop;
        overflow_d = overflow_q || drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {DROP_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            symbols_q   <= '0;
            run_q       <= 1'b0;
            mon_clear_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            symbols_q   <= symbols_d;
            run_q       <= run_d;
            mon_clear_q <= mon_clear_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign symbols   = symbols_q;
    assign run       = run_q;
    assign mon_clear = mon_clear_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = !accepting || !fifo_empty;

endmodule

// File: tb/tb_rm_symbol_feeder.sv
// Directed bench for rm_symbol_feeder: a default instance plus a small one for counter saturation.
module tb_rm_symbol_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_sym = 8'h00;
    logic [7:0]  symbols;
    logic        run, mon_clear, busy, overflow;
    logic [15:0] drop_cnt;

    logic        s_en = 1'b0, s_flush = 1'b0, s_in_valid = 1'b0;
    logic [7:0]  s_in_sym = 8'h00;
    logic [7:0]  s_symbols;
    logic        s_run, s_mon_clear, s_busy, s_overflow;
    logic [3:0]  s_drop_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rm_symbol_feeder #(.DEPTH(8), .EOT_SYM(8'hFF), .DROP_W(16)) u_dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in_sym(in_sym), .symbols(symbols), .run(run), .mon_clear(mon_clear),
        .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    rm_symbol_feeder #(.DEPTH(2), .EOT_SYM(8'hFF), .DROP_W(4)) u_dut_small (
        .clk(clk), .reset(reset), .en(s_en), .flush(s_flush), .in_valid(s_in_valid),
        .in_sym(s_in_sym), .symbols(s_symbols), .run(s_run), .mon_clear(s_mon_clear),
        .busy(s_busy), .overflow(s_overflow), .drop_cnt(s_drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_checks++; if (symbols !== 8'h00) begin n_fails++; $display("FAIL reset_symbols: got %h want 00", symbols); end
        n_checks++; if (run !== 1'b0) begin n_fails++; $display("FAIL reset_run: got %b want 0", run); end
        n_checks++; if (mon_clear !== 1'b0) begin n_fails++; $display("FAIL reset_mon_clear: got %b want 0", mon_clear); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (drop_cnt !== 16'h0000) begin n_fails++; $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        en = 1'b1;
        step();
        in_valid = 1'b1;
        in_sym = exp[0];
        step();
        n_checks++; if (run !== 1'b0) begin n_fails++; $display("FAIL stream_accept_run: got %b want 0", run); end
        for (int i = 0; i < 3; i++) begin
            if (i < 2) in_sym = exp[i+1];
            else in_valid = 1'b0;
            step();
            n_checks++;
            if (run !== 1'b1 || symbols !== exp[i]) begin
                n_fails++; $display("FAIL stream_out%0d: got run=%b sym=%h want run=1 sym=%h", i, run, symbols, exp[i]);
            end
        end
        step();
        n_checks++; if (run !== 1'b0 || symbols !== 8'h33) begin n_fails++; $display("FAIL stream_idle: got run=%b sym=%h want run=0 sym=33", run, symbols); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL stream_busy: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        en = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_sym = 8'(8'hA0 + i);
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (drop_cnt !== 16'd2) begin n_fails++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
        n_checks++; if (overflow !== 1'b1) begin n_fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_checks++; if (run !== 1'b0 || busy !== 1'b1) begin n_fails++; $display("FAIL ovf_hold: got run=%b busy=%b want run=0 busy=1", run, busy); end
        en = 1'b1;
        step();
        n_checks++; if (run !== 1'b0) begin n_fails++; $display("FAIL ovf_enter_stream_run: got %b want 0", run); end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (run !== 1'b1 || symbols !== 8'(8'hA0 + i)) begin
                n_fails++; $display("FAIL ovf_out%0d: got run=%b sym=%h want run=1 sym=%h", i, run, symbols, 8'(8'hA0 + i));
            end
        end
        step();
        n_checks++; if (run !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL ovf_drained: got run=%b busy=%b want run=0 busy=0", run, busy); end
    endtask

    task automatic test_flush();
        logic [7:0] exp [3];
        exp[0] = 8'hB1; exp[1] = 8'hB2; exp[2] = 8'hB3;
        en = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_sym = exp[i];
            step();
        end
        in_sym = exp[2];
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_sym = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (run !== 1'b1 || symbols !== exp[i] || mon_clear !== 1'b0) begin
                n_fails++; $display("FAIL flush_data%0d: got run=%b sym=%h clr=%b want run=1 sym=%h clr=0", i, run, symbols, mon_clear, exp[i]);
            end
        end
        step();
        n_checks++; if (run !== 1'b1 || symbols !== 8'hFF || mon_clear !== 1'b0) begin n_fails++; $display("FAIL flush_eot: got run=%b sym=%h clr=%b want run=1 sym=ff clr=0", run, symbols, mon_clear); end
        step();
        n_checks++; if (run !== 1'b0 || mon_clear !== 1'b1) begin n_fails++; $display("FAIL flush_clear: got run=%b clr=%b want run=0 clr=1", run, mon_clear); end
        step();
        in_valid = 1'b0;
        n_checks++; if (mon_clear !== 1'b0 || run !== 1'b0) begin n_fails++; $display("FAIL flush_done: got run=%b clr=%b want run=0 clr=0", run, mon_clear); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL flush_ignored_input: got busy=%b want 0", busy); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fails++; $display("FAIL flush_drop_cnt: got %0d want 2", drop_cnt); end
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_checks++; if (run !== 1'b1 || symbols !== 8'hFF) begin n_fails++; $display("FAIL flush0_eot: got run=%b sym=%h want run=1 sym=ff", run, symbols); end
        step();
        n_checks++; if (run !== 1'b0 || mon_clear !== 1'b1) begin n_fails++; $display("FAIL flush0_clear: got run=%b clr=%b want run=0 clr=1", run, mon_clear); end
        step();
        n_checks++; if (mon_clear !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL flush0_done: got clr=%b busy=%b want 0 0", mon_clear, busy); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sym = 8'(8'h40 + i);
            step();
        end
        in_valid = 1'b0;
        en = 1'b1;
        step();
        for (int j = 0; j < 38; j++) begin
            if (j < 30) begin
                in_valid = 1'b1;
                in_sym = 8'(8'h48 + j);
            end else begin
                in_valid = 1'b0;
            end
            step();
            n_checks++;
            if (run !== 1'b1 || symbols !== 8'(8'h40 + j)) begin
                n_fails++; $display("FAIL b2b_out%0d: got run=%b sym=%h want run=1 sym=%h", j, run, symbols, 8'(8'h40 + j));
            end
        end
        step();
        n_checks++; if (run !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL b2b_end: got run=%b busy=%b want 0 0", run, busy); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fails++; $display("FAIL b2b_drop_cnt: got %0d want 2", drop_cnt); end
    endtask

    task automatic test_drop_saturation();
        int d;
        s_en = 1'b0;
        for (int i = 0; i < 22; i++) begin
            s_in_valid = 1'b1;
            s_in_sym = 8'(i);
            step();
            d = (i >= 2) ? i - 1 : 0;
            if (d > 15) d = 15;
            n_checks++;
            if (s_drop_cnt !== 4'(d)) begin
                n_fails++; $display("FAIL sat_drop_cnt%0d: got %0d want %0d", i, s_drop_cnt, d);
            end
        end
        s_in_valid = 1'b0;
        n_checks++; if (s_overflow !== 1'b1 || s_run !== 1'b0) begin n_fails++; $display("FAIL sat_flags: got ovf=%b run=%b want 1 0", s_overflow, s_run); end
    endtask

    task automatic test_reset_mid_drain();
        en = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sym = 8'(8'hD0 + i);
            step();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        n_checks++; if (run !== 1'b1 || symbols !== 8'hD1) begin n_fails++; $display("FAIL rst_pre_drain: got run=%b sym=%h want run=1 sym=d1", run, symbols); end
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (run !== 1'b0 || symbols !== 8'h00 || mon_clear !== 1'b0) begin n_fails++; $display("FAIL rst_async_out: got run=%b sym=%h clr=%b want 0 00 0", run, symbols, mon_clear); end
        n_checks++; if (overflow !== 1'b0 || drop_cnt !== 16'h0000) begin n_fails++; $display("FAIL rst_async_ovf: got ovf=%b cnt=%h want 0 0000", overflow, drop_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        #2;
        reset = 1'b1;
        en = 1'b1;
        step();
        in_valid = 1'b1;
        in_sym = 8'h77;
        step();
        in_valid = 1'b0;
        n_checks++; if (run !== 1'b0) begin n_fails++; $display("FAIL rst_after_accept: got run=%b want 0", run); end
        step();
        n_checks++; if (run !== 1'b1 || symbols !== 8'h77) begin n_fails++; $display("FAIL rst_after_stream: got run=%b sym=%h want run=1 sym=77", run, symbols); end
        step();
        n_checks++; if (run !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL rst_after_end: got run=%b busy=%b want 0 0", run, busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_flush();
        test_flush_empty();
        test_back_to_back();
        test_drop_saturation();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rm_symbol_feeder.md
# rm_symbol_feeder

Transmit-side front end for the runtime-monitor clusters: it accepts 8-bit trace symbols from the core's commit/trace tap, buffers them, and drives the `symbols`/`run` stream consumed by each cluster top (e.g. the cluster-6 load/word monitor). It also sequences end-of-trace handling: drain, emit an end-of-trace symbol, then pulse a monitor clear. The trace source cannot be stalled, so overflow is handled by drop-and-count rather than backpressure.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, minimum 2.
- `EOT_SYM`, 8'hFF: symbol emitted once after a flush drains.
- `DROP_W`, 16: width of the saturating drop counter.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  streaming enable; low stalls output, FIFO still accepts.
- `flush`  in  1  one-cycle request: drain, emit EOT, clear monitors.
- `in_valid`  in  1  trace symbol present this cycle.
- `in_sym`  in  8  trace symbol.
- `symbols`  out  8  registered symbol to monitor clusters.
- `run`  out  1  registered; high for exactly the cycles `symbols` is valid.
- `mon_clear`  out  1  registered one-cycle pulse after EOT.
- `busy`  out  1  state is not IDLE/STREAM, or FIFO non-empty.
- `overflow`  out  1  sticky; set on first drop, cleared only by reset.
- `drop_cnt`  out  DROP_W  saturating count of dropped symbols.

## Operation
- Reset (`reset`=0): FIFO empty, state IDLE, `symbols`=8'h00, `run`=0, `mon_clear`=0, `overflow`=0, `drop_cnt`=0.
- Accept: `in_valid` && FIFO not full && state in {IDLE, STREAM} writes `in_sym`.
- Drop: `in_valid` && FIFO full in IDLE/STREAM → no write, `drop_cnt`+1 (saturates at all-ones), `overflow` set.
- `in_valid` during DRAIN/EOT/CLEAR: ignored, not counted.
- States:
  - IDLE: `en`=1 → STREAM; `flush` → DRAIN.
  - STREAM: each cycle FIFO non-empty, pop head into `symbols`, `run`=1; else `run`=0, `symbols` holds. `en`=0 → IDLE (no pop that cycle). `flush` → DRAIN.
  - DRAIN: pops regardless of `en`; at FIFO empty → EOT.
  - EOT: `symbols`=`EOT_SYM`, `run`=1 for one cycle → CLEAR.
  - CLEAR: `run`=0, `mon_clear`=1 for one cycle → STREAM if `en` else IDLE.
- `flush` outside IDLE/STREAM ignored. `flush` with `in_valid` in the same cycle: symbol accepted (if room) before drain.
- Simultaneous push and pop in STREAM allowed; occupancy unchanged; full FIFO pops and accepts in the same cycle (no drop).

## Timing
- Symbol accepted at edge t into empty FIFO, STREAM: `run`=1 with that symbol from edge t+1 (one-cycle latency).
- Sustained throughput one symbol/cycle; order preserved.
- `run` never high for two different cycles with the same popped entry.
- `flush` at edge t with k entries queued: data `run` pulses at t+1..t+k, EOT at t+k+1, `mon_clear` at t+k+2; k=0 → EOT at t+1.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); queued data discarded; release synchronous to `clk` by the integrator.

## Structure
- `rm_feeder_pkg`: state enum (IDLE, STREAM, DRAIN, EOT, CLEAR), default `EOT_SYM`, symbol width constant 8.
- Sub-module `rm_sym_fifo`: DEPTH×8 circular buffer, wrap-around read/write pointers with extra MSB for full/empty, same-cycle push/pop.
- Top holds FSM, output registers, drop counter.

## Test plan
- Reset then `en`=1, push 8'h11, 8'h22, 8'h33 back-to-back → `run`=1 on three consecutive cycles carrying 11,22,33, first one cycle after acceptance.
- DEPTH=8, `en`=0, push 10 symbols → 8 stored, `drop_cnt`=2, `overflow`=1; `en`=1 → exactly 8 symbols out in order.
- Queue 3 symbols, pulse `flush` → 3 data pulses, then 8'hFF with `run`=1, then `mon_clear`=1 one cycle, `run`=0; inputs during drain ignored, `drop_cnt` unchanged.
- FIFO full in STREAM with continuous `in_valid` → pop and push same cycle, no drops, pointer wrap exercised over ≥3 wraps.
- `drop_cnt` preloaded to near all-ones via forced drops → saturates at 16'hFFFF, no wrap to 0.
- Assert `reset` mid-drain → `run`, `mon_clear`, `symbols`, `overflow`, `drop_cnt` zero immediately; after release, first push streams normally.
